operand_fetch_stage: RTL

- Decode-to-execute pipeline stage that sits between the instruction decoder and the ALU, around the register file.
- Drives the register file read addresses and captures the combinational read data.
- Resolves RAW hazards by forwarding from the EX and WB stages, and inserts bubbles on load-use hazards.
- Presents registered operands to execute under a valid/ready handshake; flush support is included for branches.

---
 rtl/operand_fetch_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register file read addresses, resolves RAW
// hazards by forwarding from EX and WB, stalls on load-use, and presents
// registered operands to execute.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. On the input side the decoder must keep its instruction stable while
// in_ready is low. On the output side out_* stay stable while out_valid is
// high and out_ready is low. A flush in the same cycle as an input transfer
// discards that instruction; the decoder still sees it as consumed.
module operand_fetch_stage #(
  parameter int NUM_DOMAINS = 1,
  localparam int W = NUM_DOMAINS * 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_opcode,
  input  logic [2:0]   in_rs1,
  input  logic [2:0]   in_rs2,
  input  logic [2:0]   in_rd,
  input  logic [W-1:0] in_imm,
  input  logic         in_use_imm,
  output logic [2:0]   rf_rd_addr1,
  output logic [2:0]   rf_rd_addr2,
  input  logic [W-1:0] rf_rd_data1,
  input  logic [W-1:0] rf_rd_data2,
  input  logic         ex_fwd_en,
  input  logic [2:0]   ex_fwd_addr,
  input  logic [W-1:0] ex_fwd_data,
  input  logic         ex_is_load,
  input  logic         wb_wr_en,
  input  logic [2:0]   wb_wr_addr,
  input  logic [W-1:0] wb_wr_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_opcode,
  output logic [2:0]   out_rd,
  output logic [W-1:0] out_op_a,
  output logic [W-1:0] out_op_b,
  output logic         hazard_stall,
  output logic [7:0]   stall_count
);

  logic         r_out_valid;
  logic [4:0]   r_out_opcode;
  logic [2:0]   r_out_rd;
  logic [W-1:0] r_out_op_a;
  logic [W-1:0] r_out_op_b;
  logic [7:0]   r_stall_count;

  logic         w_ex_hit_a;
  logic         w_ex_hit_b;
  logic         w_wb_hit_a;
  logic         w_wb_hit_b;
  logic [W-1:0] w_op_a;
  logic [W-1:0] w_op_b;
  logic         w_hazard;
  logic         w_in_ready;
  logic         w_capture;

  // Register file is read in the capture cycle, straight from the decoder.
  assign rf_rd_addr1 = in_rs1;
  assign rf_rd_addr2 = in_rs2;

  // EX forwarding is only usable when the EX result is not a pending load.
  assign w_ex_hit_a = ex_fwd_en & (ex_fwd_addr == in_rs1) & ~ex_is_load;
  assign w_ex_hit_b = ex_fwd_en & (ex_fwd_addr == in_rs2) & ~ex_is_load;
  // WB bypass covers the write that the register file only commits at the edge.
  assign w_wb_hit_a = wb_wr_en & (wb_wr_addr == in_rs1);
  assign w_wb_hit_b = wb_wr_en & (wb_wr_addr == in_rs2);

  // Operand selection: EX beats WB beats the register file; immediate wins for B.
  always_comb begin
    w_op_a = rf_rd_data1;
    if (w_ex_hit_a)      w_op_a = ex_fwd_data;
    else if (w_wb_hit_a) w_op_a = wb_wr_data;

    w_op_b = rf_rd_data2;
    if (in_use_imm)      w_op_b = in_imm;
    else if (w_ex_hit_b) w_op_b = ex_fwd_data;
    else if (w_wb_hit_b) w_op_b = wb_wr_data;
  end

  // A load in EX whose destination feeds this instruction cannot be forwarded yet.
  assign w_hazard = in_valid & ex_fwd_en & ex_is_load &
                    ((ex_fwd_addr == in_rs1) | (~in_use_imm & (ex_fwd_addr == in_rs2)));

  assign w_in_ready = (~r_out_valid | out_ready) & ~w_hazard & ~reset;
  assign w_capture  = in_valid & w_in_ready & ~flush;

  // Output register: flush beats capture, capture beats drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_opcode  <= '0;
      r_out_rd      <= '0;
      r_out_op_a    <= '0;
      r_out_op_b    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_hazard && (r_stall_count != 8'hFF)) begin
        r_stall_count <= r_stall_count + 8'd1;
      end
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_capture) begin
        r_out_valid  <= 1'b1;
        r_out_opcode <= in_opcode;
        r_out_rd     <= in_rd;
        r_out_op_a   <= w_op_a;
        r_out_op_b   <= w_op_b;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign hazard_stall = w_hazard;
  assign out_valid    = r_out_valid;
  assign out_opcode   = r_out_opcode;
  assign out_rd       = r_out_rd;
  assign out_op_a     = r_out_op_a;
  assign out_op_b     = r_out_op_b;
  assign stall_count  = r_stall_count;

endmodule
